// File: rtl/fx_log_avg.sv
// fx_log_avg: averages 2^AVG_LOG2 signed 16.16 log10 samples per output.
// Result handshakes out with valid/ready; a synchronous clear aborts the
// partial average. Optional macro FX_LOG_DB_SCALE_EN multiplies the average
// by 10 (log10 -> dB) with saturation to the signed 32-bit range.
module fx_log_avg #(
    parameter int AVG_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        clear,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sat
);

    // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
    localparam int AW = 32 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] sum;
    logic        [CW-1:0] cnt_q, cnt_d;
    logic        [31:0]   data_q, data_d;
    logic                 sat_q, sat_d;
    logic signed [31:0]   avg;
    logic        [32:0]   fmt;

    // Final output formatting: returns {sat, data}.
    function automatic logic [32:0] fmt_out(input logic signed [31:0] a);
`ifdef FX_LOG_DB_SCALE_EN
        logic signed [35:0] a36;
        logic signed [35:0] p;
        a36 = 36'(a);
        p   = (a36 <<< 3) + (a36 <<< 1);
        if (p > 36'sh07FFFFFFF)
            return {1'b1, 32'h7FFFFFFF};
        else if (p < -36'sh080000000)
            return {1'b1, 32'h80000000};
        else
            return {1'b0, p[31:0]};
`else
        return {1'b0, a};
`endif
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACC;
        else        state_q <= state_d;
    end

    // Next state, accumulation and result capture.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        sat_d     = sat_q;
        in_ready  = (state_q == ACC);
        out_valid = (state_q == HOLD);
        sum       = acc_q + AW'($signed(in_data));
        avg       = 32'(sum >>> AVG_LOG2);
        fmt       = fmt_out(avg);
        case (state_q)
            ACC: begin
                if (clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = HOLD;
                        data_d  = fmt[31:0];
                        sat_d   = fmt[32];
                    end
                end
            end
            HOLD: begin
                // Clear drops the result; a handshake retires it.
                if (clear || out_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // Accumulator, counter and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            sat_q  <= sat_d;
        end
    end

    assign out_data = data_q;
    assign out_sat  = sat_q;

endmodule

// File: tb/tb_fx_log_avg.sv
// Bench for fx_log_avg: directed cases plus randomized traffic against a
// sample-list reference model.
module tb_fx_log_avg;

    localparam int A = 3;
    localparam int N = 1 << A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_q[$];
    bit          m_hold = 1'b0;
    logic [31:0] m_data = '0;
    logic        m_sat  = 1'b0;

    fx_log_avg #(.AVG_LOG2(A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .clear    (clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Mean of the collected samples, rounded toward minus infinity,
    // optionally times ten with clipping. Returns {sat, data}.
    function automatic logic [32:0] ref_out(input longint s);
        longint q;
        longint r;
        q = s / N;
        if ((s % N) != 0 && s < 0) q = q - 1;
`ifdef FX_LOG_DB_SCALE_EN
        r = q * 10;
        if (r > 64'sd2147483647)       return {1'b1, 32'h7FFFFFFF};
        else if (r < -64'sd2147483648) return {1'b1, 32'h80000000};
        else                            return {1'b0, r[31:0]};
`else
        r = q;
        return {1'b0, r[31:0]};
`endif
    endfunction

    task automatic model_edge(input logic iv, input logic [31:0] d, input logic clr, input logic ordy);
        longint      s;
        logic [32:0] o;
        if (!m_hold) begin
            if (clr) m_q.delete();
            else if (iv) begin
                m_q.push_back(d);
                if (m_q.size() == N) begin
                    s = 0;
                    foreach (m_q[i]) s += longint'($signed(m_q[i]));
                    o      = ref_out(s);
                    m_data = o[31:0];
                    m_sat  = o[32];
                    m_hold = 1'b1;
                    m_q.delete();
                end
            end
        end else if (clr || ordy) begin
            m_hold = 1'b0;
        end
    endtask

    // One clock: drive inputs, let the edge happen, check on the falling edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic clr, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        clear     = clr;
        out_ready = ordy;
        @(posedge clk);
        model_edge(iv, d, clr, ordy);
        @(negedge clk);
        chk("in_ready", {31'b0, in_ready}, {31'b0, !m_hold});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_hold});
        if (m_hold) begin
            chk("out_data", out_data, m_data);
            chk("out_sat", {31'b0, out_sat}, {31'b0, m_sat});
        end
    endtask

    task automatic burst(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) step(1'b1, d, 1'b0, 1'b1);
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic pulse_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_sat", {31'b0, out_sat}, 32'd0);
        m_q.delete();
        m_hold = 1'b0;
        m_data = '0;
        m_sat  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        pulse_reset();

        // constant streams
        burst(32'h00010000, N);
        step(1'b0, '0, 1'b0, 1'b1);
        burst(32'hFFFF0000, N);
        step(1'b0, '0, 1'b0, 1'b1);
        burst(32'h00000001, N / 2);
        burst(32'h00000000, N / 2);
        step(1'b0, '0, 1'b0, 1'b1);
        burst(32'h7FFF0000, N);
        step(1'b0, '0, 1'b0, 1'b1);
        burst(32'h80000000, N);
        step(1'b0, '0, 1'b0, 1'b1);

        // back-pressure in HOLD with extra samples offered
        burst(32'h00030000, N);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h12345678, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // handshake cycle followed immediately by a new sample
        burst(32'h00040000, N);
        burst(32'h00060000, N);
        step(1'b0, '0, 1'b0, 1'b1);

        // clear in ACC beats a coincident sample
        burst(32'h00050000, 3);
        step(1'b1, 32'h00050000, 1'b1, 1'b1);
        burst(32'h00020000, N);
        step(1'b0, '0, 1'b0, 1'b1);

        // clear in HOLD drops the result even with out_ready high
        burst(32'hFFFE8000, N);
        step(1'b0, '0, 1'b1, 1'b1);

        // reset mid-accumulation, then a clean average
        burst(32'h00090000, 4);
        pulse_reset();
        burst(32'h00020000, N);
        pulse_reset();
        burst(32'hFFFFFFFD, N);
        step(1'b0, '0, 1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0:       d = 32'h7FFFFFFF - $urandom_range(0, 3);
                1:       d = 32'h80000000 + $urandom_range(0, 3);
                default: d = $urandom;
            endcase
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
